// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N tap counter family.
package counter_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_e;

   localparam logic UP   = 1'b1;
   localparam logic DOWN = 1'b0;

   // Constant-foldable ceil(log2(value)); used for parameter legality checks.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned pow;
      res = 0;
      pow = 1;
      while (pow < value) begin
         pow = pow << 1;
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational successor of a modulo-MODULUS up/down count, plus at-terminal flag.
module counter_step
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 3,
   parameter int unsigned MODULUS = 8
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   output logic [WIDTH-1:0] next_c,
   output logic             at_term_c
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   always_comb begin
      next_c    = count;
      at_term_c = 1'b0;
      if (up == UP) begin
         at_term_c = (count == MAX_VAL);
         next_c    = at_term_c ? '0 : count + WIDTH'(1);
      end else begin
         at_term_c = (count == '0);
         next_c    = at_term_c ? MAX_VAL : count - WIDTH'(1);
      end
   end

endmodule

// File: rtl/counter_mod_tap.sv
// Modulo-N up/down counter with load, terminal-count pulse, optional one-shot
// halt, and a single registered tap bit q = count[TAP].
module counter_mod_tap
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 3,
   parameter int unsigned MODULUS = 8,
   parameter int unsigned TAP     = WIDTH - 1,
   parameter int unsigned ONESHOT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             q,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
   localparam logic             ONESHOT_EN = (ONESHOT != 0);

   if (TAP >= WIDTH || MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_param_check
      $error("counter_mod_tap: illegal WIDTH/MODULUS/TAP combination");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] step_next;
   logic             step_at_term;

   counter_step #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_step (
      .count     (count_q),
      .up        (up),
      .next_c    (step_next),
      .at_term_c (step_at_term)
   );

   // Next-state: load beats step beats hold; HALT only leaves on load.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      if (load) begin
         count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
         state_d = RUN;
         done_d  = 1'b0;
      end else if (en && state_q == RUN) begin
         tc_d = step_at_term;
         if (step_at_term && ONESHOT_EN) begin
            state_d = HALT;
            done_d  = 1'b1;
         end else begin
            count_d = step_next;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         count_q <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   assign count = count_q;
   assign q     = count_q[TAP];
   assign tc    = tc_q;
   assign done  = done_q;

endmodule

// File: tb/tb_counter_mod_tap.sv
// Directed bench for counter_mod_tap: three configurations share stimulus,
// a reference model fills a scoreboard, and directed literals cross-check it.
module tb_counter_mod_tap;

   logic       clk;
   logic       reset;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;

   logic [2:0] cnt_a, cnt_b;
   logic [3:0] cnt_c;
   logic       q_a, tc_a, done_a;
   logic       q_b, tc_b, done_b;
   logic       q_c, tc_c, done_c;

   int total;
   int bad;

   typedef struct {
      int   cnt;
      logic q;
      logic tc;
      logic done;
   } exp_t;

   exp_t sb[$];

   localparam int MODS[3] = '{6, 6, 16};
   localparam int WIDS[3] = '{3, 3, 4};
   localparam int TAPS[3] = '{2, 2, 0};
   localparam bit ONES[3] = '{1'b0, 1'b1, 1'b0};

   int m_cnt[3];
   bit m_tc[3];
   bit m_done[3];

   localparam int FR_A[7]    = '{1, 2, 3, 4, 5, 0, 1};
   localparam int FR_TC[7]   = '{0, 0, 0, 0, 0, 1, 0};
   localparam int DN_A[5]    = '{5, 4, 3, 3, 3};
   localparam int DN_TC[5]   = '{1, 0, 0, 0, 0};
   localparam int OS_B[4]    = '{4, 5, 5, 5};
   localparam int OS_TC[4]   = '{0, 0, 1, 0};
   localparam int OS_DONE[4] = '{0, 0, 1, 1};

   counter_mod_tap #(.WIDTH(3), .MODULUS(6), .TAP(2), .ONESHOT(0)) dut_a (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val[2:0]), .count(cnt_a), .q(q_a), .tc(tc_a), .done(done_a));

   counter_mod_tap #(.WIDTH(3), .MODULUS(6), .TAP(2), .ONESHOT(1)) dut_b (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val[2:0]), .count(cnt_b), .q(q_b), .tc(tc_b), .done(done_b));

   counter_mod_tap #(.WIDTH(4), .MODULUS(16), .TAP(0), .ONESHOT(0)) dut_c (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .count(cnt_c), .q(q_c), .tc(tc_c), .done(done_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_cnt(input int i);
      case (i)
         0:       return 32'(cnt_a);
         1:       return 32'(cnt_b);
         default: return 32'(cnt_c);
      endcase
   endfunction

   function automatic logic [31:0] obs_q(input int i);
      case (i)
         0:       return 32'(q_a);
         1:       return 32'(q_b);
         default: return 32'(q_c);
      endcase
   endfunction

   function automatic logic [31:0] obs_tc(input int i);
      case (i)
         0:       return 32'(tc_a);
         1:       return 32'(tc_b);
         default: return 32'(tc_c);
      endcase
   endfunction

   function automatic logic [31:0] obs_done(input int i);
      case (i)
         0:       return 32'(done_a);
         1:       return 32'(done_b);
         default: return 32'(done_c);
      endcase
   endfunction

   // Reference behaviour of one counter for one clock edge.
   function automatic void model_edge(input int i, input logic e, input logic u,
                                      input logic l, input logic [3:0] lv);
      int top;
      int v;
      top = MODS[i] - 1;
      v   = int'(lv) & ((1 << WIDS[i]) - 1);
      m_tc[i] = 1'b0;
      if (l) begin
         m_cnt[i]  = (v > top) ? top : v;
         m_done[i] = 1'b0;
      end else if (e && !m_done[i]) begin
         if (u) begin
            if (m_cnt[i] == top) begin
               m_tc[i] = 1'b1;
               if (ONES[i]) m_done[i] = 1'b1;
               else         m_cnt[i]  = 0;
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
            end
         end else begin
            if (m_cnt[i] == 0) begin
               m_tc[i] = 1'b1;
               if (ONES[i]) m_done[i] = 1'b1;
               else         m_cnt[i]  = top;
            end else begin
               m_cnt[i] = m_cnt[i] - 1;
            end
         end
      end
   endfunction

   task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lv);
      @(negedge clk);
      en       = e;
      up       = u;
      load     = l;
      load_val = lv;
      for (int i = 0; i < 3; i++) begin
         exp_t x;
         model_edge(i, e, u, l, lv);
         x.cnt  = m_cnt[i];
         x.q    = logic'((m_cnt[i] >> TAPS[i]) & 1);
         x.tc   = m_tc[i];
         x.done = m_done[i];
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         exp_t x;
         x = sb.pop_front();
         check($sformatf("dut%0d_count", i), obs_cnt(i), 32'(x.cnt));
         check($sformatf("dut%0d_q", i), obs_q(i), 32'(x.q));
         check($sformatf("dut%0d_tc", i), obs_tc(i), 32'(x.tc));
         check($sformatf("dut%0d_done", i), obs_done(i), 32'(x.done));
      end
   endtask

   // Asserts reset between edges, expects immediate zeros, releases at negedge.
   task automatic mid_reset(input string tag);
      #2;
      en    = 1'b0;
      load  = 1'b0;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_dut%0d_count", tag, i), obs_cnt(i), 32'd0);
         check($sformatf("%s_dut%0d_q", tag, i), obs_q(i), 32'd0);
         check($sformatf("%s_dut%0d_tc", tag, i), obs_tc(i), 32'd0);
         check($sformatf("%s_dut%0d_done", tag, i), obs_done(i), 32'd0);
         m_cnt[i]  = 0;
         m_tc[i]   = 1'b0;
         m_done[i] = 1'b0;
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int tc_seen;
      total    = 0;
      bad      = 0;
      reset    = 1'b1;
      en       = 1'b0;
      up       = 1'b1;
      load     = 1'b0;
      load_val = 4'd0;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]  = 0;
         m_tc[i]   = 1'b0;
         m_done[i] = 1'b0;
      end

      // Power-on reset
      #2;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("por_dut%0d_count", i), obs_cnt(i), 32'd0);
         check($sformatf("por_dut%0d_q", i), obs_q(i), 32'd0);
         check($sformatf("por_dut%0d_tc", i), obs_tc(i), 32'd0);
         check($sformatf("por_dut%0d_done", i), obs_done(i), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;

      // Free-run up through the wrap
      for (int k = 0; k < 7; k++) begin
         step(1'b1, 1'b1, 1'b0, 4'd0);
         check("free_a_count", 32'(cnt_a), 32'(FR_A[k]));
         check("free_a_tc", 32'(tc_a), 32'(FR_TC[k]));
         check("free_a_q", 32'(q_a), 32'(FR_A[k] >= 4));
      end

      // Down wrap from 0, then disable at 3
      step(1'b0, 1'b1, 1'b1, 4'd0);
      for (int k = 0; k < 5; k++) begin
         step(k < 3, 1'b0, 1'b0, 4'd0);
         check("down_a_count", 32'(cnt_a), 32'(DN_A[k]));
         check("down_a_tc", 32'(tc_a), 32'(DN_TC[k]));
      end

      // Load clamps and beats enable
      step(1'b1, 1'b1, 1'b1, 4'd7);
      check("clamp_a_count", 32'(cnt_a), 32'd5);
      check("clamp_a_tc", 32'(tc_a), 32'd0);
      check("clamp_c_count", 32'(cnt_c), 32'd7);
      step(1'b1, 1'b1, 1'b1, 4'd2);
      check("load2_a_count", 32'(cnt_a), 32'd2);

      // One-shot run into HALT, then reload
      step(1'b0, 1'b1, 1'b1, 4'd3);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b1, 1'b0, 4'd0);
         check("os_b_count", 32'(cnt_b), 32'(OS_B[k]));
         check("os_b_tc", 32'(tc_b), 32'(OS_TC[k]));
         check("os_b_done", 32'(done_b), 32'(OS_DONE[k]));
      end
      step(1'b0, 1'b1, 1'b1, 4'd0);
      check("reload_b_count", 32'(cnt_b), 32'd0);
      check("reload_b_done", 32'(done_b), 32'd0);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 4'd0);
      check("resume_b_count", 32'(cnt_b), 32'd4);
      check("pre_reset_a_count", 32'(cnt_a), 32'd4);
      mid_reset("rst_run");

      // Reset while the one-shot counter sits in HALT
      for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 4'd0);
      check("halt_b_done", 32'(done_b), 32'd1);
      check("halt_b_count", 32'(cnt_b), 32'd5);
      mid_reset("rst_halt");

      // Full 16-state wrap on the wide counter, tapping bit 0
      tc_seen = 0;
      for (int k = 0; k < 32; k++) begin
         step(1'b1, 1'b1, 1'b0, 4'd0);
         check("sweep_c_count", 32'(cnt_c), 32'((k + 1) % 16));
         check("sweep_c_q", 32'(q_c), 32'((k + 1) & 1));
         if (tc_c) tc_seen++;
      end
      check("sweep_c_tc_pulses", 32'(tc_seen), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_mod_tap.md
# counter_mod_tap

Parametrised successor to the single-bit optimisation counter: a modulo-N up/down counter with enable, synchronous load, terminal-count pulse, optional one-shot mode and a single registered tap output `q`. It is the standard timing/divider primitive for synthesis-optimisation experiments. `q` exposes one chosen count bit, so unused bits of `count` can be left open and trimmed by synthesis.

## Interface
- `WIDTH`, 3: counter width in bits; must satisfy 2**WIDTH >= MODULUS.
- `MODULUS`, 8: count range 0..MODULUS-1; valid range 2..2**WIDTH.
- `TAP`, WIDTH-1: bit of `count` driven onto `q`; 0 <= TAP < WIDTH.
- `ONESHOT`, 0: 0 = free-running wrap; 1 = stop at terminal value.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  step enable.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value for load.
- `count`  out  WIDTH  registered count.
- `q`  out  1  equals `count[TAP]`.
- `tc`  out  1  registered terminal-count pulse.
- `done`  out  1  one-shot halted flag; constant 0 when ONESHOT=0.

## Operation
- Terminal value T: MODULUS-1 when `up`=1; 0 when `up`=0. Wrap value: 0 when up, MODULUS-1 when down.
- Priority per edge: `load` > `en` > hold.
- Load: `count` <= min(load_val, MODULUS-1). State returns to RUN, `done` <= 0, `tc` <= 0.
- Step (en=1, load=0, state RUN):
  - count != T: count +/- 1.
  - count == T, ONESHOT=0: count <= wrap value, `tc` <= 1.
  - count == T, ONESHOT=1: count holds, `tc` <= 1, state <= HALT, `done` <= 1.
- en=0: count holds, `tc` <= 0.
- FSM (used only when ONESHOT=1): RUN -> HALT on a step at T. HALT -> RUN only on `load`. In HALT, `en` and `up` are ignored and `tc` stays 0.
- Changing `up` mid-count reverses direction from the current value. There is no skip or reset to a boundary.
- Arithmetic is WIDTH-bit. The next value never leaves 0..MODULUS-1 for any input sequence.

## Timing
- Reset (reset=0, asynchronous, takes effect immediately): count=0, q=0, tc=0, done=0, state=RUN. Release is synchronous to the next edge.
- All outputs are registered. There are no combinational input-to-output paths.
- Latency: 1 cycle from `en`/`load` to `count`/`q`.
- `tc` is high for exactly one cycle, in the cycle `count` shows the wrap value (or the held T in one-shot).
- `done` rises in the same cycle as the one-shot `tc`. It stays high until a load edge or reset.
- Reset asserted mid-count or in HALT aborts immediately to the reset values. No pulse is emitted.

## Structure
- Shared package `counter_pkg`:
  - state typedef: RUN, HALT.
  - `clog2` function for the elaboration check.
  - direction constants UP=1, DOWN=0.
- Elaboration-time check: reject `TAP >= WIDTH` and `MODULUS > 2**WIDTH`.
- One sub-module: `counter_step`, purely combinational. Inputs: count, up, MODULUS. Outputs: next value and at-terminal flag. The top level holds the registers and the FSM.

## Test plan
Configuration WIDTH=3, MODULUS=6, TAP=2 unless noted.
- Free-run up: reset released, en=1, up=1 -> count 0,1,2,3,4,5,0,1. `tc` high only in the cycle count=0 after 5. `q`=1 exactly while count is 4 or 5.
- Down wrap: en=1, up=0 from 0 -> count 5,4,3 and `tc` high in the cycle count first shows 5. Set en=0 at count=3 -> count holds 3 and `tc`=0.
- Load clamp and priority: load_val=7 with load=1, en=1 -> count=5 next cycle and `tc`=0. load_val=2 -> count=2.
- One-shot (ONESHOT=1): load 3, then en=1, up=1 -> count 4,5,5,5. `tc` is a single pulse with the first held 5. `done`=1 and holds. Pulse load with load_val=0 -> count=0, `done`=0, counting resumes.
- Async reset mid-operation: drop reset between edges at count=4 -> count=0, q=0, tc=0, done=0 before the next edge. Repeat in HALT and confirm the same result.
- Parameter sweep: WIDTH=4, MODULUS=16, TAP=0 up -> full 0..15 wrap. `q` toggles every cycle and `tc` pulses every 16 cycles.
